// File: rtl/fir_ctrl_pkg.sv
// Shared state encoding and parameter floors for the FIR run/sample sequencer.
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_STEP = 3'd2,
        ST_LOAD = 3'd3,
        ST_CONV = 3'd4,
        ST_WAIT = 3'd5
    } state_t;

    localparam int MIN_SAMPLE_DIV = 8;
    localparam int MIN_DEB_CYC    = 2;

    // Raises an out-of-range parameter to its floor instead of building a broken counter.
    function automatic int clamp_min(input int value, input int floor_value);
        return (value < floor_value) ? floor_value : value;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low push-button.
// press_evt pulses for one cycle when the accepted level falls; releases produce nothing.
module btn_debounce
    import fir_ctrl_pkg::*;
#(
    parameter int DEB_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press_evt
);

    localparam int               DEB      = clamp_min(DEB_CYC, MIN_DEB_CYC);
    localparam int               CNT_W    = $clog2(DEB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments keep the two synchroniser stages as two distinct flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every stage resets to the released level, so leaving reset never looks like a press.
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            level     <= 1'b1;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            sync_a    <= btn_n;
            sync_b    <= sync_a;
            press_evt <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt       <= '0;
                level     <= sync_b;
                press_evt <= ~sync_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fir_run_ctrl.sv
// Run/sample sequencer: debounced start/stop, paced lfsr_step -> ma_load -> bcd_start strobes.
// Define FIR_RUN_CTRL_SINGLE_STEP_EN to add the step_n single-sample button.
module fir_run_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int DEB_CYC    = 250000,
    parameter int CNT_W      = 36
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             btn_n,
`ifdef FIR_RUN_CTRL_SINGLE_STEP_EN
    input  logic             step_n,
`endif
    input  logic             bcd_done,
    output logic             run,
    output logic             dp_clr,
    output logic             lfsr_step,
    output logic             ma_load,
    output logic             bcd_start,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             overrun
);

    localparam int               DIV      = clamp_min(SAMPLE_DIV, MIN_SAMPLE_DIV);
    localparam int               DIV_W    = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] divider;
    logic             stop_req;
    logic             conv_first;
    logic             press_evt;
    logic             step_evt;
    logic             single;
    logic             running;
    logic             done_ok;
    logic             slot_over;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn (
        .clk       (CLOCK_50),
        .rst       (rst),
        .btn_n     (btn_n),
        .press_evt (press_evt)
    );

`ifdef FIR_RUN_CTRL_SINGLE_STEP_EN
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_step (
        .clk       (CLOCK_50),
        .rst       (rst),
        .btn_n     (step_n),
        .press_evt (step_evt)
    );

    // Marks a one-shot sample launched from IDLE; it never raises run.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            single <= 1'b0;
        end else if (state == ST_IDLE) begin
            single <= step_evt && !press_evt;
        end
    end
`else
    assign step_evt = 1'b0;
    assign single   = 1'b0;
`endif

    assign running   = (state != ST_IDLE) && !single;
    // A done coinciding with bcd_start belongs to no conversion of ours.
    assign done_ok   = (state == ST_CONV) && bcd_done && !conv_first;
    assign slot_over = (divider == DIV_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (press_evt) begin
                    state_nxt = ST_CLR;
                end else if (step_evt) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_CLR:  state_nxt = ST_STEP;
            ST_STEP: state_nxt = stop_req ? ST_IDLE : ST_LOAD;
            ST_LOAD: state_nxt = ST_CONV;
            ST_CONV: begin
                if (done_ok) begin
                    if (stop_req || single) begin
                        state_nxt = ST_IDLE;
                    end else if (slot_over) begin
                        state_nxt = ST_STEP;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (stop_req) begin
                    state_nxt = ST_IDLE;
                end else if (slot_over) begin
                    state_nxt = ST_STEP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The divider restarts on every entry into STEP, so the STEP cycle itself is count 0.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            divider    <= '0;
            stop_req   <= 1'b0;
            conv_first <= 1'b0;
            sample_cnt <= '0;
            overrun    <= 1'b0;
        end else begin
            conv_first <= (state == ST_LOAD);

            if (state_nxt == ST_STEP) begin
                divider <= '0;
            end else if (running && !slot_over) begin
                divider <= divider + DIV_W'(1);
            end

            if (state == ST_IDLE) begin
                stop_req <= 1'b0;
            end else if (running && press_evt) begin
                stop_req <= 1'b1;
            end

            if (state == ST_CLR) begin
                sample_cnt <= '0;
                overrun    <= 1'b0;
            end else if (done_ok) begin
                if (sample_cnt != '1) begin
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
                if (running && slot_over) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // NOTE: every output gets a default first so this block never infers a latch.
    always_comb begin
        run       = 1'b0;
        dp_clr    = 1'b0;
        lfsr_step = 1'b0;
        ma_load   = 1'b0;
        bcd_start = 1'b0;
        // Qualified with rst so nothing strobes while a reset is being applied.
        if (!rst) begin
            run       = running;
            dp_clr    = (state == ST_CLR);
            lfsr_step = (state == ST_STEP);
            ma_load   = (state == ST_LOAD);
            bcd_start = (state == ST_CONV) && conv_first;
        end
    end

endmodule

// File: tb/tb_fir_run_ctrl.sv
// Self-checking bench for fir_run_ctrl: delay table, randomised converter delays, reset and glitch cases.
`timescale 1ns/1ps
module tb_fir_run_ctrl;

    localparam int SAMPLE_DIV = 16;
    localparam int DEB_CYC    = 4;

    typedef struct {
        int delay;
        int n;
        int gap;
        int ovr;
        bit echo;
        bit defer;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        btn_n;
    logic        bcd_done;
`ifdef FIR_RUN_CTRL_SINGLE_STEP_EN
    logic        step_n = 1'b1;
`endif
    logic        run, dp_clr, lfsr_step, ma_load, bcd_start, overrun;
    logic [35:0] sample_cnt;
    logic        run3, dp_clr3, lfsr_step3, ma_load3, bcd_start3, overrun3;
    logic [2:0]  sample_cnt3;

    fir_run_ctrl #(.SAMPLE_DIV(SAMPLE_DIV), .DEB_CYC(DEB_CYC), .CNT_W(36)) dut (
        .CLOCK_50   (clk),
        .rst        (rst),
        .btn_n      (btn_n),
`ifdef FIR_RUN_CTRL_SINGLE_STEP_EN
        .step_n     (step_n),
`endif
        .bcd_done   (bcd_done),
        .run        (run),
        .dp_clr     (dp_clr),
        .lfsr_step  (lfsr_step),
        .ma_load    (ma_load),
        .bcd_start  (bcd_start),
        .sample_cnt (sample_cnt),
        .overrun    (overrun)
    );

    fir_run_ctrl #(.SAMPLE_DIV(SAMPLE_DIV), .DEB_CYC(DEB_CYC), .CNT_W(3)) dut3 (
        .CLOCK_50   (clk),
        .rst        (rst),
        .btn_n      (btn_n),
`ifdef FIR_RUN_CTRL_SINGLE_STEP_EN
        .step_n     (step_n),
`endif
        .bcd_done   (bcd_done),
        .run        (run3),
        .dp_clr     (dp_clr3),
        .lfsr_step  (lfsr_step3),
        .ma_load    (ma_load3),
        .bcd_start  (bcd_start3),
        .sample_cnt (sample_cnt3),
        .overrun    (overrun3)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int done_at = -1;
    int conv_delay = 3;
    bit conv_echo = 1'b0;
    bit rand_delay = 1'b0;
    int step_q[$];
    int load_q[$];
    int start_q[$];
    int delay_q[$];
    int dones = 0;
    int last_done = -1;
    int clr_cnt = 0;
    int clr_cyc = -1;
    int cnt_at_start0 = -1;
    int ovr_at_step0 = -1;
    int strobe_viol = 0;
    int shadow_viol = 0;
    int prev_ovr = 0;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Next lfsr_step follows the previous by one full slot, or by the conversion itself
    // (start 2 cycles after step, done k later, next step one cycle after done) when that is longer.
    function automatic int model_gap(input int k);
        return (k + 3 > SAMPLE_DIV) ? k + 3 : SAMPLE_DIV;
    endfunction

    // Conversion reports after the slot expired when done lands on or after the slot's last cycle.
    function automatic bit model_overrun(input int k);
        return (k + 2 >= SAMPLE_DIV - 1);
    endfunction

    // One cycle: observe outputs at the falling edge, then play the converter for the next edge.
    task automatic tick();
        int strobes;
        longint sat;
        @(negedge clk);
        cyc++;
        if (bcd_start) begin
            if (rand_delay) conv_delay = int'($urandom_range(1, 24));
            if (start_q.size() == 0) cnt_at_start0 = int'(sample_cnt);
            done_at = cyc + conv_delay;
            start_q.push_back(cyc);
            delay_q.push_back(conv_delay);
        end
        bcd_done = (cyc == done_at) || (conv_echo && bcd_start);
        if (cyc == done_at) begin
            dones++;
            last_done = cyc;
        end
        if (lfsr_step) begin
            if (step_q.size() == 0) ovr_at_step0 = int'(overrun);
            step_q.push_back(cyc);
        end
        if (ma_load) load_q.push_back(cyc);
        if (dp_clr) begin
            clr_cnt++;
            clr_cyc = cyc;
        end
        strobes = int'(dp_clr) + int'(lfsr_step) + int'(ma_load) + int'(bcd_start);
        if (strobes > 1) strobe_viol++;
        if ({run3, dp_clr3, lfsr_step3, ma_load3, bcd_start3, overrun3} !=
            {run, dp_clr, lfsr_step, ma_load, bcd_start, overrun}) shadow_viol++;
        sat = (sample_cnt > 36'd7) ? 64'd7 : longint'(sample_cnt);
        if (longint'(sample_cnt3) != sat) shadow_viol++;
    endtask

    task automatic press(input int low_cycles);
        btn_n = 1'b0;
        repeat (low_cycles) tick();
        btn_n = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_n = 1'b1;
        bcd_done = 1'b0;
        done_at = -1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Start a run, stop it at the n-th bcd_start, then score the run.
    task automatic run_entry(input vec_t v, input bit randomised);
        int guard;
        int run_fall;
        int exp_gap;
        int exp_ovr;
        check("ovr_hold_idle", overrun, prev_ovr);
        conv_delay = v.delay;
        conv_echo  = v.echo;
        rand_delay = randomised;
        step_q.delete();
        load_q.delete();
        start_q.delete();
        delay_q.delete();
        dones = 0;
        clr_cnt = 0;
        clr_cyc = -1;
        cnt_at_start0 = -1;
        ovr_at_step0 = -1;

        press(10);
        guard = 0;
        while (start_q.size() < v.n && guard < 1000) begin
            tick();
            guard++;
        end
        check("start_wait", longint'(start_q.size() >= v.n), 1);

        press(10);
        guard = 0;
        while (run && guard < 200) begin
            tick();
            guard++;
        end
        run_fall = cyc;
        check("run_drop", run, 0);
        repeat (20) tick();

        check("clr_once", clr_cnt, 1);
        check("steps", step_q.size(), v.n);
        if (step_q.size() > 0 && load_q.size() > 0 && start_q.size() > 0) begin
            check("step_after_clr", step_q[0] - clr_cyc, 1);
            check("load_lag", load_q[0] - step_q[0], 1);
            check("start_lag", start_q[0] - step_q[0], 2);
        end
        check("cnt_before_done", cnt_at_start0, 0);
        check("ovr_cleared_on_start", ovr_at_step0, 0);

        exp_ovr = randomised ? 0 : v.ovr;
        if (randomised) begin
            foreach (delay_q[i]) if (model_overrun(delay_q[i])) exp_ovr = 1;
        end
        for (int i = 1; i < step_q.size(); i++) begin
            exp_gap = randomised ? model_gap(delay_q[i-1]) : v.gap;
            check("step_gap", step_q[i] - step_q[i-1], exp_gap);
        end

        check("done_count", dones, v.n);
        check("sample_cnt", sample_cnt, v.n);
        check("sample_cnt_w3", sample_cnt3, (v.n > 7) ? 7 : v.n);
        check("overrun", overrun, exp_ovr);
        if (!randomised && v.defer) check("stop_after_done", run_fall, last_done + 1);
        prev_ovr   = exp_ovr;
        rand_delay = 1'b0;
        conv_echo  = 1'b0;
    endtask

    initial begin
        int guard;
        int n_steps;
        int n_clr;
        vec_t rv;

        //            delay  n  gap  ovr echo defer
        vecs[0] = '{3,     5, 16,  0,  1'b0, 1'b0};
        vecs[1] = '{1,     3, 16,  0,  1'b0, 1'b0};
        vecs[2] = '{12,    3, 16,  0,  1'b0, 1'b1};
        vecs[3] = '{13,    3, 16,  1,  1'b0, 1'b1};
        vecs[4] = '{20,    4, 23,  1,  1'b1, 1'b1};
        vecs[5] = '{3,     9, 16,  0,  1'b0, 1'b0};

        rst = 1'b1;
        btn_n = 1'b1;
        bcd_done = 1'b0;
        do_reset();
        tick();
        check("rst_run", run, 0);
        check("rst_dp_clr", dp_clr, 0);
        check("rst_lfsr_step", lfsr_step, 0);
        check("rst_ma_load", ma_load, 0);
        check("rst_bcd_start", bcd_start, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_overrun", overrun, 0);

        clr_cnt = 0;
        for (int g = 1; g <= 3; g++) begin
            press(g);
            repeat (15) tick();
            check("glitch_no_clr", clr_cnt, 0);
            check("glitch_run", run, 0);
        end

        foreach (vecs[i]) run_entry(vecs[i], 1'b0);

        for (int r = 0; r < 4; r++) begin
            rv = '{0, int'($urandom_range(2, 5)), 0, 0, 1'b0, 1'b0};
            run_entry(rv, 1'b1);
        end

        // Reset in the middle of a WAIT slot.
        conv_delay = 3;
        step_q.delete();
        press(10);
        guard = 0;
        while (step_q.size() < 2 && guard < 200) begin
            tick();
            guard++;
        end
        check("steps_before_rst", longint'(step_q.size() >= 2), 1);
        repeat (8) tick();
        check("cnt_before_rst", sample_cnt, 2);
        check("run_before_rst", run, 1);
        rst = 1'b1;
        #1;
        check("run_gated_in_rst", run, 0);
        tick();
        done_at = -1;
        check("mid_rst_run", run, 0);
        check("mid_rst_strobes", {dp_clr, lfsr_step, ma_load, bcd_start}, 0);
        check("mid_rst_sample_cnt", sample_cnt, 0);
        check("mid_rst_overrun", overrun, 0);
        rst = 1'b0;
        n_steps = step_q.size();
        n_clr = clr_cnt;
        repeat (20) tick();
        check("no_step_after_rst", step_q.size(), n_steps);
        check("no_clr_after_rst", clr_cnt, n_clr);
        check("idle_after_rst", run, 0);

        check("strobe_onehot", strobe_viol, 0);
        check("cnt_w3_shadow", shadow_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_run_ctrl.md
Name: fir_run_ctrl

Overview:
- Run/sample sequencer for the FIR moving-average datapath.
- Turns the raw start/stop push-button into a clean run state.
- Paces samples from CLOCK_50 and issues one-cycle strobes in order: lfsr step, moving-average load, binary-to-BCD start. Waits for BCD done before the next sample.
- Counts completed samples; sits between the button, the lfsr/moving_average/BinaryBCDBehav instances and the display logic.

Parameters:
- SAMPLE_DIV, 50000: CLOCK_50 cycles between consecutive lfsr_step pulses (minimum 8).
- DEB_CYC, 250000: cycles btn_n must be stable before a level change is accepted (minimum 2).
- CNT_W, 36: width of sample_cnt.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_n  in  1  raw asynchronous toggle button, active-low.
- bcd_done  in  1  one-cycle pulse from converter, result valid.
- run  out  1  high while sampling is enabled.
- dp_clr  out  1  one-cycle clear pulse to lfsr/moving_average on start.
- lfsr_step  out  1  one-cycle pulse, advance LFSR.
- ma_load  out  1  one-cycle pulse, moving average accepts X1.
- bcd_start  out  1  one-cycle pulse, begin conversion.
- sample_cnt  out  CNT_W  completed samples since last start.
- overrun  out  1  sticky: a conversion finished after the sample slot expired.

Behaviour:
- Reset (sync, rst=1): state IDLE. run, dp_clr, lfsr_step, ma_load, bcd_start and overrun = 0. sample_cnt = 0. Divider = 0. Debouncer stable level = 1 (released).
- Button input: 2-flop synchroniser, then debounce counter. The accepted level changes only after DEB_CYC consecutive equal samples. press_evt = one cycle on accepted 1->0 transition. Releases are ignored.
- States: IDLE, CLR, STEP, LOAD, CONV, WAIT.
- IDLE: run=0. On press_evt -> CLR.
- CLR (1 cycle): run=1, dp_clr=1, sample_cnt<=0, overrun<=0, divider<=0. -> STEP.
- STEP (1 cycle): lfsr_step=1, divider<=0. -> LOAD.
- LOAD (1 cycle): ma_load=1. -> CONV.
- CONV: bcd_start=1 on the first cycle in the state only. Waits for bcd_done. A bcd_done on the same cycle as bcd_start is ignored.
  - On bcd_done: sample_cnt increments, saturating at all-ones (no wrap).
  - If the divider has already reached SAMPLE_DIV-1, set overrun and go straight to STEP. Otherwise -> WAIT.
- WAIT: when divider == SAMPLE_DIV-1 -> STEP. Steady-state period is exactly SAMPLE_DIV cycles between lfsr_step pulses.
- Divider counts every cycle while run=1 and saturates at SAMPLE_DIV-1.
- Stop: a press_evt while run=1 sets stop_req.
  - In WAIT or STEP with stop_req set: -> IDLE next cycle.
  - In LOAD or CONV, stop is deferred until the in-flight sample finishes (bcd_done). That sample is counted, then -> IDLE.
  - sample_cnt and overrun hold their values in IDLE.
- A press_evt in CLR is treated as a stop request.
- At most one strobe output is high in any cycle.
- rst mid-operation: returns to IDLE within one cycle with all outputs at reset values. No strobe is emitted in the reset cycle or in the cycle after it.

Optional Feature:
- Macro: FIR_RUN_CTRL_SINGLE_STEP_EN.
- With the macro defined:
  - Extra port step_n (in, 1, active-low), debounced identically to btn_n.
  - A press of step_n in IDLE runs exactly one STEP->LOAD->CONV sequence, sample_cnt +1, then returns to IDLE with run held 0. No dp_clr is issued.
  - step_n presses while run=1 are ignored.
- Without the macro: no step_n port and no associated logic.

Decomposition:
- Package fir_ctrl_pkg:
  - state enum (IDLE, CLR, STEP, LOAD, CONV, WAIT) as a 3-bit encoding;
  - localparams for the minimum SAMPLE_DIV and DEB_CYC values.
- Sub-module btn_debounce (params DEB_CYC): synchroniser, debounce counter, press_evt output. Instantiated once for btn_n, and a second time for step_n when the optional feature is enabled.

Test Plan:
- Use SAMPLE_DIV=16 and DEB_CYC=4 for all scenarios.
- Reset, then btn_n low 10 cycles -> one dp_clr, then lfsr_step, ma_load and bcd_start on consecutive cycles. sample_cnt=0 until bcd_done.
- Converter model returns bcd_done 3 cycles after bcd_start; run 5 samples -> lfsr_step exactly every 16 cycles, sample_cnt=5, overrun=0.
- Converter delay 20 cycles -> next lfsr_step on the cycle after bcd_done, overrun=1, overrun stays 1 until the next start.
- Stop pressed during CONV -> no further lfsr_step; run drops the cycle after bcd_done; sample_cnt includes that sample.
- btn_n glitches of 1-3 cycles -> no press_evt and no state change. rst asserted mid-WAIT -> all outputs 0 and sample_cnt=0 next cycle.
- CNT_W=3: run 9 samples -> sample_cnt saturates at 7.
